id_ex_stage: RTL and testbench

- ID/EX pipeline stage boundary of the 5-stage MIPS core, directly downstream of the forwarding unit.
- Consumes the forwarding selects for rs and rt and resolves the ID-stage operands from the register file or the EX, MEM and WR bypass buses.
- Detects load-use hazards and inserts bubbles, then registers instruction, PC, operands and control into the ID/EX register.
- Handles global hold, flush and a saturating load-use stall counter.

---
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded operands, inserts load-use
// bubbles, and honours hold/flush with a saturating bubble counter.
module id_ex_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [1:0]        id_a_sel,
  input  logic [1:0]        id_b_sel,
  input  logic [31:0]       ex_fwd_data,
  input  logic [31:0]       mem_fwd_data,
  input  logic [31:0]       wr_fwd_data,
  input  logic              ex_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [31:0]       ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic              stall_id,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        lu;

  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];

  // Forwarding selects are not qualified for $0, so force zero here.
  always_comb begin
    op_a = id_rs_data;
    case (id_a_sel)
      2'b00:   op_a = id_rs_data;
      2'b01:   op_a = ex_fwd_data;
      2'b10:   op_a = mem_fwd_data;
      default: op_a = wr_fwd_data;
    endcase
    if (rs == 5'd0) op_a = '0;
  end

  always_comb begin
    op_b = id_rt_data;
    case (id_b_sel)
      2'b00:   op_b = id_rt_data;
      2'b01:   op_b = ex_fwd_data;
      2'b10:   op_b = mem_fwd_data;
      default: op_b = wr_fwd_data;
    endcase
    if (rt == 5'd0) op_b = '0;
  end

  assign lu = id_valid & ex_is_load &
              (((id_a_sel == 2'b01) & (rs != 5'd0)) |
               ((id_b_sel == 2'b01) & (rt != 5'd0)));

  assign stall_id = (lu | hold) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_instr     <= '0;
      ex_pc        <= '0;
      ex_ctrl      <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      lu_stall_cnt <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_instr <= '0;
      ex_pc    <= '0;
      ex_ctrl  <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else if (!hold) begin
      if (lu) begin
        ex_valid <= 1'b0;
        ex_instr <= '0;
        ex_pc    <= '0;
        ex_ctrl  <= '0;
        ex_a     <= '0;
        ex_b     <= '0;
        if (lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      end else begin
        ex_valid <= id_valid;
        ex_instr <= id_instr;
        ex_pc    <= id_pc;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
        ex_a     <= op_a;
        ex_b     <= op_b;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a behavioural model;
// a second instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       id_rs_data;
  logic [31:0]       id_rt_data;
  logic [1:0]        id_a_sel;
  logic [1:0]        id_b_sel;
  logic [31:0]       ex_fwd_data;
  logic [31:0]       mem_fwd_data;
  logic [31:0]       wr_fwd_data;
  logic              ex_is_load;
  logic              hold;
  logic              flush;

  logic              ex_valid;
  logic [31:0]       ex_instr;
  logic [31:0]       ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_a;
  logic [31:0]       ex_b;
  logic              stall_id;
  logic [15:0]       lu_stall_cnt;

  logic              s_valid;
  logic [31:0]       s_instr;
  logic [31:0]       s_pc;
  logic [CTRL_W-1:0] s_ctrl;
  logic [31:0]       s_a;
  logic [31:0]       s_b;
  logic              s_stall;
  logic [1:0]        s_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_instr, m_pc, m_a, m_b;
  logic [CTRL_W-1:0] m_ctrl;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_ctrl(id_ctrl), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .wr_fwd_data(wr_fwd_data), .ex_is_load(ex_is_load), .hold(hold),
    .flush(flush), .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .stall_id(stall_id),
    .lu_stall_cnt(lu_stall_cnt));

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_ctrl(id_ctrl), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .wr_fwd_data(wr_fwd_data), .ex_is_load(ex_is_load), .hold(hold),
    .flush(flush), .ex_valid(s_valid), .ex_instr(s_instr), .ex_pc(s_pc),
    .ex_ctrl(s_ctrl), .ex_a(s_a), .ex_b(s_b), .stall_id(s_stall),
    .lu_stall_cnt(s_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rs, input int rt);
    logic [31:0] r;
    r = $urandom;
    r[25:21] = 5'(rs);
    r[20:16] = 5'(rt);
    return r;
  endfunction

  function automatic logic [31:0] resolve(input logic [4:0] f, input logic [1:0] sel,
                                          input logic [31:0] rf);
    logic [31:0] src [4];
    src[0] = rf; src[1] = ex_fwd_data; src[2] = mem_fwd_data; src[3] = wr_fwd_data;
    return (f == 5'd0) ? 32'd0 : src[sel];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_instr = 0; m_pc = 0; m_ctrl = 0; m_a = 0; m_b = 0;
    m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic bubble();
    m_valid = 0; m_instr = 0; m_pc = 0; m_ctrl = 0; m_a = 0; m_b = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, "_instr"}, ex_instr, m_instr);
    chk({tag, "_pc"},    ex_pc, m_pc);
    chk({tag, "_ctrl"},  32'(ex_ctrl), 32'(m_ctrl));
    chk({tag, "_a"},     ex_a, m_a);
    chk({tag, "_b"},     ex_b, m_b);
    chk({tag, "_cnt"},   32'(lu_stall_cnt), 32'(m_cnt));
    chk({tag, "_cnt2"},  32'(s_cnt), 32'(m_cnt2));
  endtask

  // One clock of the pipeline: check comb stall, advance the model, check regs.
  task automatic step(input string tag);
    logic [4:0] rs, rt;
    bit lu;
    #1;
    rs = id_instr[25:21];
    rt = id_instr[20:16];
    lu = id_valid && ex_is_load &&
         ((id_a_sel == 2'b01 && rs != 0) || (id_b_sel == 2'b01 && rt != 0));
    chk({tag, "_stall"}, 32'(stall_id), 32'((lu || hold) && !flush));
    if (flush) bubble();
    else if (hold) ;
    else if (lu) begin
      bubble();
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_valid = id_valid;
      m_instr = id_instr;
      m_pc    = id_pc;
      m_ctrl  = id_valid ? id_ctrl : '0;
      m_a     = resolve(rs, id_a_sel, id_rs_data);
      m_b     = resolve(rt, id_b_sel, id_rt_data);
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic idle();
    id_valid = 0; id_instr = 0; id_pc = 0; id_ctrl = 0;
    id_rs_data = 0; id_rt_data = 0; id_a_sel = 0; id_b_sel = 0;
    ex_fwd_data = 0; mem_fwd_data = 0; wr_fwd_data = 0;
    ex_is_load = 0; hold = 0; flush = 0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Plain capture
    id_valid = 1; id_instr = mk_instr(3, 4); id_pc = 32'h400; id_ctrl = 16'h1234;
    id_rs_data = 32'h11; id_rt_data = 32'h22;
    step("cap");
    chk("cap_a_const", ex_a, 32'h11);
    chk("cap_b_const", ex_b, 32'h22);
    chk("cap_v_const", 32'(ex_valid), 32'd1);

    // Forward mux
    id_instr = mk_instr(3, 4); id_a_sel = 2'b01; id_b_sel = 2'b11;
    ex_fwd_data = 32'hAAAA0001; wr_fwd_data = 32'h5;
    step("fwd");
    chk("fwd_a_const", ex_a, 32'hAAAA0001);
    chk("fwd_b_const", ex_b, 32'h5);

    // $0 override, even with a load in EX
    id_instr = mk_instr(0, 4); id_a_sel = 2'b01; id_b_sel = 2'b00;
    ex_fwd_data = 32'hDEADBEEF; ex_is_load = 1;
    #1 chk("zero_stall_const", 32'(stall_id), 32'd0);
    step("zero");
    chk("zero_a_const", ex_a, 32'd0);

    // Load-use: one bubble, then the MEM forward resolves it
    id_instr = mk_instr(3, 5); id_a_sel = 2'b00; id_b_sel = 2'b01;
    #1 chk("lu_stall_const", 32'(stall_id), 32'd1);
    step("lu");
    chk("lu_v_const", 32'(ex_valid), 32'd0);
    chk("lu_ctrl_const", 32'(ex_ctrl), 32'd0);
    chk("lu_cnt_const", 32'(lu_stall_cnt), 32'd1);
    ex_is_load = 0; id_b_sel = 2'b10; mem_fwd_data = 32'h77;
    step("lu_mem");
    chk("lu_mem_b_const", ex_b, 32'h77);
    chk("lu_mem_v_const", 32'(ex_valid), 32'd1);

    // Hold beats load-use
    id_instr = mk_instr(3, 5); id_b_sel = 2'b01; ex_is_load = 1; hold = 1;
    step("hold");
    chk("hold_b_const", ex_b, 32'h77);
    chk("hold_cnt_const", 32'(lu_stall_cnt), 32'd1);

    // Flush beats load-use
    hold = 0; flush = 1;
    step("flush");
    chk("flush_v_const", 32'(ex_valid), 32'd0);
    chk("flush_cnt_const", 32'(lu_stall_cnt), 32'd1);
    flush = 0;

    // Saturation on the 2-bit counter
    for (int i = 0; i < 4; i++) step("sat");
    chk("sat_cnt_const", 32'(s_cnt), 32'd3);
    step("sat_more");
    chk("sat_stay_const", 32'(s_cnt), 32'd3);

    // Asynchronous reset mid-stall
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("arst");
    chk("arst_stall", 32'(stall_id), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 9) < 8);
      id_instr     = mk_instr($urandom_range(0, 7), $urandom_range(0, 7));
      id_pc        = $urandom;
      id_ctrl      = 16'($urandom);
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_a_sel     = 2'($urandom);
      id_b_sel     = 2'($urandom);
      ex_fwd_data  = $urandom;
      mem_fwd_data = $urandom;
      wr_fwd_data  = $urandom;
      ex_is_load   = ($urandom_range(0, 9) < 3);
      hold         = ($urandom_range(0, 99) < 15);
      flush        = ($urandom_range(0, 99) < 10);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
